instr_mem_loader: RTL and testbench

- Byte-stream writer that fills instruction memory, which the PC-driven fetch stage reads.
- Takes bytes from the UART receiver and assembles big-endian 32-bit words.
- Writes the words to sequential word-aligned addresses starting at 0.
- Holds the PC via o_halt until a complete program, terminated by a halt sentinel word, has been written.

---
 rtl/instr_mem_loader_if.sv | 28 ++
 rtl/instr_mem_loader.sv | 151 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-source / instruction-memory-write bundle between the UART front end and instr_mem_loader.
// The loader consumes it through the slave modport; the byte source drives it through master.
interface instr_mem_loader_if #(
    parameter int MEM_DEPTH = 256
);
    localparam int CW = $clog2(MEM_DEPTH) + 1;

    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          halt;
    logic          done;
    logic          error;
    logic [CW-1:0] word_count;

    modport master (
        output start, rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata, halt, done, error, word_count
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata, halt, done, error, word_count
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Assembles big-endian words from a UART byte stream and writes them to instruction memory
// from address 0, holding the PC until a program ending in the halt sentinel has been stored.
module instr_mem_loader #(
    parameter int          MEM_DEPTH      = 256,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF
) (
    input logic              clk,
    input logic              i_reset,
    instr_mem_loader_if.slave bus
);
    localparam int CW = $clog2(MEM_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    byte_cnt, byte_cnt_nxt;
    logic [31:0]   word, word_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [31:0]   addr, addr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          mem_we_q, mem_we_nxt;
    logic [31:0]   mem_addr_q, mem_addr_nxt;
    logic [31:0]   mem_wdata_q, mem_wdata_nxt;
    logic          halt_q, halt_nxt;
    logic          done_q, done_nxt;
    logic          error_q, error_nxt;

    logic [31:0] word_shift;
    logic [CW:0] count_inc;
    logic        timer_expired;

    assign word_shift    = {word[23:0], bus.rx_data};
    assign count_inc     = {1'b0, count} + {{CW{1'b0}}, 1'b1};
    assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RECV;
            RECV: begin
                if (bus.rx_valid) begin
                    if (byte_cnt == 2'd3) state_nxt = WRITE;
                end else if (timer_expired) begin
                    state_nxt = ERROR;
                end
            end
            WRITE: begin
                if (word == HALT_WORD)                      state_nxt = DONE;
                else if (count_inc == (CW+1)'(MEM_DEPTH))   state_nxt = ERROR;
                else                                        state_nxt = RECV;
            end
            DONE:    if (bus.start) state_nxt = RECV;
            ERROR:   if (bus.start) state_nxt = RECV;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next-values; every output is registered from these.
    always_comb begin
        byte_cnt_nxt  = byte_cnt;
        word_nxt      = word;
        timer_nxt     = timer;
        addr_nxt      = addr;
        count_nxt     = count;
        case (state)
            RECV: begin
                if (bus.rx_valid) begin
                    word_nxt     = word_shift;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    timer_nxt    = '0;
                end else if (!timer_expired) begin
                    timer_nxt    = timer + TW'(1);
                end
            end
            WRITE: begin
                addr_nxt  = addr + 32'd4;
                count_nxt = count + CW'(1);
                timer_nxt = '0;
                // A byte arriving during the write starts the next word only if loading continues.
                if (state_nxt == RECV && bus.rx_valid) begin
                    word_nxt     = word_shift;
                    byte_cnt_nxt = 2'd1;
                end
            end
            default: begin
                if (bus.start) begin
                    byte_cnt_nxt = '0;
                    timer_nxt    = '0;
                    addr_nxt     = '0;
                    count_nxt    = '0;
                end
            end
        endcase

        mem_we_nxt    = (state_nxt == WRITE);
        mem_addr_nxt  = (state_nxt == WRITE) ? addr       : mem_addr_q;
        mem_wdata_nxt = (state_nxt == WRITE) ? word_shift : mem_wdata_q;
        halt_nxt      = (state_nxt != DONE);
        done_nxt      = (state_nxt == DONE);
        error_nxt     = (state_nxt == ERROR);
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt    <= '0;
            word        <= '0;
            timer       <= '0;
            addr        <= '0;
            count       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halt_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            byte_cnt    <= byte_cnt_nxt;
            word        <= word_nxt;
            timer       <= timer_nxt;
            addr        <= addr_nxt;
            count       <= count_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            halt_q      <= halt_nxt;
            done_q      <= done_nxt;
            error_q     <= error_nxt;
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.halt       = halt_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.word_count = count;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed scenarios plus randomized programs checked against
// a word-level model of the load (group bytes big-endian, stop at sentinel or full memory).
module tb_instr_mem_loader;
    localparam int          DEPTH = 4;
    localparam int          TMO   = 16;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam int          CW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.MEM_DEPTH(DEPTH)) bus ();

    instr_mem_loader #(
        .MEM_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .HALT_WORD(HALT)
    ) dut (
        .clk(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  stim_q[$];
    bit          exp_done, exp_err;
    int          exp_cnt;

    always @(negedge clk)
        if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) step();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
    endtask

    task automatic wait_end(input string name);
        for (int i = 0; i < 60 && !(bus.done || bus.error); i++) step();
        checks++;
        if (!(bus.done || bus.error)) begin
            errors++;
            $display("FAIL %s_end: done=%0b error=%0b, required one of them high within 60 cycles",
                     name, bus.done, bus.error);
        end
    endtask

    // Reference: bytes form big-endian words at consecutive addresses; the load ends at the
    // sentinel (done) or when DEPTH words are stored without one (error).
    task automatic run_model();
        logic [31:0] w;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_cnt  = 0;
        for (int i = 0; i + 3 < stim_q.size() && !exp_done && !exp_err; i += 4) begin
            w = {stim_q[i], stim_q[i+1], stim_q[i+2], stim_q[i+3]};
            exp_q.push_back({32'(4 * exp_cnt), w});
            exp_cnt++;
            if (w == HALT)            exp_done = 1;
            else if (exp_cnt == DEPTH) exp_err = 1;
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL rst_halt: got %0b need 1", bus.halt); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b need 0", bus.done); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL rst_error: got %0b need 0", bus.error); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b need 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h need 0", bus.mem_addr); end
        checks++; if (bus.word_count !== CW'(0)) begin errors++; $display("FAIL rst_count: got %0d need 0", bus.word_count); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal_load();
        logic [7:0] prog [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        wr_q.delete();
        pulse_start();
        foreach (prog[i]) send_byte(prog[i], 0);
        wait_end("normal");
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL normal_nwr: got %0d need 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            checks++; if (wr_q[0] !== {32'd0, 32'h2001_0005}) begin errors++; $display("FAIL normal_wr0: got %h need %h", wr_q[0], {32'd0, 32'h2001_0005}); end
            checks++; if (wr_q[1] !== {32'd4, HALT}) begin errors++; $display("FAIL normal_wr1: got %h need %h", wr_q[1], {32'd4, HALT}); end
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL normal_done: got %0b need 1", bus.done); end
        checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL normal_halt: got %0b need 0", bus.halt); end
        checks++; if (bus.word_count !== CW'(2)) begin errors++; $display("FAIL normal_count: got %0d need 2", bus.word_count); end
    endtask

    task automatic test_timeout();
        wr_q.delete();
        pulse_start();
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        repeat (TMO - 1) step();
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL tmo_early: error=%0b after %0d idle cycles need 0", bus.error, TMO - 1); end
        step();
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL tmo_error: error=%0b after %0d idle cycles need 1", bus.error, TMO); end
        checks++; if (bus.halt !== 1'b1) begin errors++; $display("FAIL tmo_halt: got %0b need 1", bus.halt); end
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL tmo_nowrite: got %0d writes need 0", wr_q.size()); end
    endtask

    task automatic test_overflow();
        wr_q.delete();
        pulse_start();
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL ovf_clear: error=%0b after start need 0", bus.error); end
        for (int i = 1; i <= DEPTH; i++) send_word(32'(i), 0);
        step();
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %0b need 1", bus.error); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ovf_done: got %0b need 0", bus.done); end
        checks++; if (wr_q.size() !== DEPTH) begin errors++; $display("FAIL ovf_nwr: got %0d need %0d", wr_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== {32'(4 * i), 32'(i + 1)}) begin
                errors++; $display("FAIL ovf_wr%0d: got %h need %h", i, wr_q[i], {32'(4 * i), 32'(i + 1)});
            end
        end
    endtask

    task automatic test_mid_load_reset();
        wr_q.delete();
        pulse_start();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 0);
        rst_n = 1'b0;
        step();
        checks++; if (bus.halt !== 1'b1 || bus.error !== 1'b0 || bus.word_count !== CW'(0)) begin
            errors++; $display("FAIL mid_rst_state: halt=%0b error=%0b count=%0d need 1 0 0", bus.halt, bus.error, bus.word_count);
        end
        rst_n = 1'b1;
        step();
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL mid_rst_nowrite: got %0d writes need 0", wr_q.size()); end
        pulse_start();
        send_word(HALT, 0);
        wait_end("mid_rst");
        checks++; if (wr_q.size() !== 1 || wr_q[0] !== {32'd0, HALT}) begin
            errors++; $display("FAIL mid_rst_wr: got %0d writes first %h need 1 write %h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'd0, {32'd0, HALT});
        end
        checks++; if (bus.done !== 1'b1 || bus.word_count !== CW'(1)) begin
            errors++; $display("FAIL mid_rst_done: done=%0b count=%0d need 1 1", bus.done, bus.word_count);
        end
    endtask

    task automatic test_ignore_reload();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        wr_q.delete();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)), i % 2);
        step();
        checks++; if (wr_q.size() !== 0 || bus.halt !== 1'b1 || bus.error !== 1'b0) begin
            errors++; $display("FAIL idle_ignore: writes=%0d halt=%0b error=%0b need 0 1 0", wr_q.size(), bus.halt, bus.error);
        end
        pulse_start();
        send_word(32'hAABB_CCDD, 0);
        send_word(HALT, 1);
        wait_end("load1");
        wr_q.delete();
        for (int i = 0; i < 8; i++) send_byte(8'(i), 0);
        checks++; if (wr_q.size() !== 0 || bus.done !== 1'b1 || bus.word_count !== CW'(2)) begin
            errors++; $display("FAIL done_ignore: writes=%0d done=%0b count=%0d need 0 1 2", wr_q.size(), bus.done, bus.word_count);
        end
        checks++; if (bus.halt !== 1'b0) begin errors++; $display("FAIL done_halt: got %0b need 0", bus.halt); end
        // Start and a byte together: the byte must be dropped.
        bus.start    = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        step();
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        checks++; if (bus.halt !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL reload_halt: halt=%0b done=%0b need 1 0", bus.halt, bus.done);
        end
        send_word(32'hAABB_CCDD, 0);
        send_word(HALT, 0);
        wait_end("reload");
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL reload_nwr: got %0d need 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            checks++; if (wr_q[0] !== {32'd0, 32'hAABB_CCDD}) begin errors++; $display("FAIL reload_wr0: got %h need %h", wr_q[0], {32'd0, 32'hAABB_CCDD}); end
            checks++; if (wr_q[1] !== {32'd4, HALT}) begin errors++; $display("FAIL reload_wr1: got %h need %h", wr_q[1], {32'd4, HALT}); end
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int          nw;
        bit          has_halt;
        for (int it = 0; it < 15; it++) begin
            stim_q.delete();
            nw       = $urandom_range(1, 6);
            has_halt = 0;
            for (int k = 0; k < nw; k++) begin
                w = $urandom;
                if (w == HALT) w = 32'd0;
                if (k == nw - 1 && ($urandom % 2 == 1)) begin w = HALT; has_halt = 1; end
                for (int b = 0; b < 4; b++) stim_q.push_back(w[31-8*b -: 8]);
            end
            if (!has_halt && nw < DEPTH) for (int b = 0; b < 4; b++) stim_q.push_back(8'hFF);
            run_model();
            wr_q.delete();
            pulse_start();
            checks++; if (bus.halt !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_start: halt=%0b done=%0b error=%0b need 1 0 0", it, bus.halt, bus.done, bus.error);
            end
            foreach (stim_q[i]) send_byte(stim_q[i], $urandom_range(0, 10));
            wait_end($sformatf("rnd%0d", it));
            checks++; if (wr_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL rnd%0d_nwr: got %0d need %0d", it, wr_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rnd%0d_wr%0d: got %h need %h", it, i, wr_q[i], exp_q[i]);
                end
            end
            checks++; if (bus.done !== exp_done || bus.error !== exp_err || bus.halt !== !exp_done) begin
                errors++; $display("FAIL rnd%0d_status: done=%0b error=%0b halt=%0b need %0b %0b %0b",
                                   it, bus.done, bus.error, bus.halt, exp_done, exp_err, !exp_done);
            end
            checks++; if (bus.word_count !== CW'(exp_cnt)) begin
                errors++; $display("FAIL rnd%0d_count: got %0d need %0d", it, bus.word_count, exp_cnt);
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_normal_load();
        test_timeout();
        test_overflow();
        test_mid_load_reset();
        test_ignore_reload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
